uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  - 8N1 UART receiver; the receive-side counterpart of uart_tx on the same serial link.
//  - Oversamples the asynchronous rx_bit line with clk, validates the start bit and samples each bit at mid-period.
//  - Presents the assembled byte with a one-cycle rx_done strobe and flags framing errors.
//  - Sits between the board RX pin and the byte-consumer logic; its bit timing is identical to uart_tx's.
// PARAMETERS
//  - CYCLES_PER_BIT  86  terminal count of the bit counter; bit period BIT_CLKS = CYCLES_PER_BIT+1 clocks (matches uart_tx)
//  - HALF_BIT        CYCLES_PER_BIT/2 (43)  counter value at which the start bit is re-checked (mid-bit)
// PORTS
//  - clk           in   1  system clock (10 MHz nominal)
//  - rst_n         in   1  asynchronous reset, active low
//  - rx_bit        in   1  serial line, asynchronous to clk, idle high
//  - rx_word       out  8  last correctly received byte, LSB received first
//  - rx_done       out  1  one-cycle pulse: rx_word updated this cycle
//  - rx_active     out  1  high while a frame is being received (START..STOP)
//  - rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
// BEHAVIOUR
//  - Interface: one clock (clk). Reset rst_n is asynchronous and active low.
//  - Reset values: rx_word=8'h00, rx_done=0, rx_active=0, rx_frame_err=0.
//    Internal: state=S_IDLE, counter=0, bit index=0, synchronizer flops=1.
//  - rx_bit passes through a 2-flop synchronizer (rx_sync); the FSM uses only rx_sync.
//  - Counter: 9 bits, counts 0..CYCLES_PER_BIT then wraps to 0; a sample is taken at the terminal count.
//  - FSM states (3-bit encoding):
//    - S_IDLE: counter=0, index=0, rx_active=0. On rx_sync==0: go to S_START, set rx_active=1.
//    - S_START: count up. At counter==HALF_BIT:
//      - rx_sync==0: go to S_DATA, counter=0 (now aligned to bit centres).
//      - rx_sync==1: glitch; return to S_IDLE with rx_active=0 and no strobe.
//    - S_DATA: at counter==CYCLES_PER_BIT, shift register[index] <= rx_sync and counter=0.
//      After index 7, go to S_STOP; otherwise index+1.
//    - S_STOP: at counter==CYCLES_PER_BIT, sample rx_sync:
//      - 1: rx_word <= shift register, rx_done=1 for one cycle, rx_active=0, go to S_IDLE.
//      - 0: rx_frame_err=1 for one cycle, rx_word unchanged, rx_active=0, go to S_BREAK.
//    - S_BREAK: wait until rx_sync==1, then go to S_IDLE. Prevents a held-low line (break) from re-triggering a start.
//  - Latency: let E0 be the edge at which S_IDLE sees rx_sync==0. The stop sample occurs at edge E0+HALF_BIT+1+9*BIT_CLKS
//    (edge 827 at defaults); rx_done/rx_frame_err are high in the cycle after that edge.
//  - Back-to-back frames: the FSM re-enters S_IDLE at mid-stop, so a start edge arriving >=1 cycle later is accepted.
//  - rx_done and rx_frame_err are never high together. rx_word is stable between rx_done strobes.
//  - Reset mid-frame: immediate return to reset values with no strobe. A partial frame is discarded.
//    After release, reception resumes from S_IDLE; a line that is low at release is treated as a start.
//  - No parity, no FIFO, no overrun detection: the consumer must take rx_word before the next rx_done (>=10 bit periods).
// STRUCTURE
//  - Shared package uart_pkg: state localparams (S_IDLE, S_START, S_DATA, S_STOP, S_BREAK),
//    default CYCLES_PER_BIT=86, and the 8-bit data-width constant, all used by both uart_tx and uart_rx.
//  - One sub-module: uart_sync (2-flop synchronizer, reset value 1, parameterised width); also reusable for other async inputs.
//  - The FSM, counters and shift register stay in uart_rx.
// TESTING
//  - Loopback uart_tx->uart_rx, data_word=8'hA5:
//    rx_done pulses once, rx_word=8'hA5, rx_frame_err never asserted, rx_active high only during the frame.
//  - Sweep 8'h00, 8'hFF, 8'h01, 8'h80 back-to-back via uart_tx with enable held high:
//    four rx_done pulses, in order, with matching rx_word.
//  - rx_bit low for 20 clks, then high:
//    no rx_done, no rx_frame_err, FSM back in S_IDLE by counter==HALF_BIT.
//  - Frame 8'h3C with the stop bit driven low and the line held low for 3 bit periods, then a valid 8'h5A frame:
//    - exactly one rx_frame_err pulse;
//    - rx_word stays at its prior value, with no false start during the low hold;
//    - then rx_done with rx_word=8'h5A.
//  - Assert rst_n low during data bit 4 of a frame:
//    outputs return to reset values asynchronously with no strobe; the next full frame 8'hC3 is received correctly.
//  - Latency check at defaults:
//    rx_done rises exactly 827 edges after the edge at which S_IDLE first sees rx_sync==0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing, data width.
package uart_pkg;

  localparam int CYCLES_PER_BIT = 86;
  localparam int DATA_W         = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs; flops reset to 1 (idle-high line).
module uart_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops to resolve metastability on the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx_bit, checks the start bit at mid-bit,
// samples data and stop bits at bit centres, strobes rx_done or rx_frame_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT_P = CYCLES_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] rx_word,
  output logic              rx_done,
  output logic              rx_active,
  output logic              rx_frame_err
);

  localparam logic [8:0] CNT_TC   = 9'(CYCLES_PER_BIT_P);
  localparam logic [8:0] CNT_HALF = 9'(CYCLES_PER_BIT_P / 2);

  logic              rx_sync;
  uart_state_t       state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              done_q, done_d;
  logic              active_q, active_d;
  logic              ferr_q, ferr_d;

  uart_sync #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_bit),
    .q_o   (rx_sync)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      word_q   <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      word_q   <= word_d;
      done_q   <= done_d;
      active_q <= active_d;
      ferr_q   <= ferr_d;
    end
  end

  // Next-state logic; strobes default low so they last exactly one cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    word_d   = word_q;
    done_d   = 1'b0;
    active_d = active_q;
    ferr_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
        if (!rx_sync) begin
          state_d  = S_START;
          active_d = 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          // Restarting the count here aligns later samples to bit centres.
          cnt_d = '0;
          if (!rx_sync) begin
            state_d = S_DATA;
          end else begin
            state_d  = S_IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_TC) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_TC) begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (rx_sync) begin
            word_d  = shift_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // A held-low line must go high again before a new start is accepted.
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_BREAK: begin
        if (rx_sync) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  assign rx_word      = word_q;
  assign rx_done      = done_q;
  assign rx_active    = active_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial driver pushes expected strobes into a
// queue, a negedge monitor pops and compares whenever rx_done/rx_frame_err fire.
module tb_uart_rx;

  localparam int BIT_CLKS = 87;
  // Stop-sample edge after E0 (43+1+9*87), plus 3 edges from line change to E0
  // (two synchronizer flops, then the edge at which S_IDLE sees rx_sync low).
  localparam int LAT_EDGES = 827 + 3;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx_bit;
  logic [7:0] rx_word;
  logic       rx_done;
  logic       rx_active;
  logic       rx_frame_err;

  exp_t       expq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_seen = 0;
  int         ferr_seen = 0;
  int         lat_c0 = 0;
  bit         lat_armed = 0;
  logic [7:0] model_word = 8'h00;
  logic       mid_active;

  uart_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_bit       (rx_bit),
    .rx_word      (rx_word),
    .rx_done      (rx_done),
    .rx_active    (rx_active),
    .rx_frame_err (rx_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_bit = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Full 8N1 frame, LSB first; records rx_active in the middle of the frame.
  task automatic send_frame(input logic [7:0] data, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(data[i]);
      if (i == 3) mid_active = rx_active;
    end
    drive_bit(stop_v);
  endtask

  task automatic push_done(input logic [7:0] data);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = data;
    expq.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    expq.push_back(e);
  endtask

  // Monitor: compares every strobe against the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lat_armed && rx_done) begin
        chk("latency_edges", cyc - lat_c0, LAT_EDGES);
        lat_armed = 0;
      end
      if (rx_done || rx_frame_err) begin
        chk("done_err_exclusive", {31'd0, rx_done & rx_frame_err}, 32'd0);
        chk("active_clear_on_strobe", {31'd0, rx_active}, 32'd0);
        if (expq.size() == 0) begin
          chk("unexpected_strobe", {30'd0, rx_done, rx_frame_err}, 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("strobe_kind", {31'd0, rx_frame_err}, {31'd0, e.is_err});
          if (e.is_err) begin
            ferr_seen++;
            chk("word_held_on_ferr", {24'd0, rx_word}, {24'd0, model_word});
          end else begin
            done_seen++;
            chk("rx_word", {24'd0, rx_word}, {24'd0, e.data});
            model_word = e.data;
          end
        end
      end else if (rx_word !== model_word) begin
        chk("word_stable", {24'd0, rx_word}, {24'd0, model_word});
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    rx_bit = 1'b1;
    mid_active = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_word", {24'd0, rx_word}, 32'h00);
    chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
    chk("reset_rx_active", {31'd0, rx_active}, 32'd0);
    chk("reset_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single frame 8'hA5 with latency measurement.
    push_done(8'hA5);
    lat_c0    = cyc;
    lat_armed = 1;
    send_frame(8'hA5, 1'b1);
    chk("a5_active_mid_frame", {31'd0, mid_active}, 32'd1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("a5_active_after", {31'd0, rx_active}, 32'd0);
    chk("a5_done_count", done_seen, 1);
    chk("latency_seen", {31'd0, lat_armed}, 32'd0);

    // Back-to-back sweep.
    push_done(8'h00);
    push_done(8'hFF);
    push_done(8'h01);
    push_done(8'h80);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h01, 1'b1);
    send_frame(8'h80, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("sweep_done_count", done_seen, 5);

    // Glitch: 20 clocks low must be rejected at the mid-start check.
    rx_bit = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_active_during", {31'd0, rx_active}, 32'd1);
    repeat (10) @(negedge clk);
    rx_bit = 1'b1;
    repeat (50) @(negedge clk);
    chk("glitch_active_after", {31'd0, rx_active}, 32'd0);
    repeat (100) @(negedge clk);
    chk("glitch_no_strobe", done_seen + ferr_seen, 5);

    // Framing error then held-low break, then a valid frame.
    push_err();
    send_frame(8'h3C, 1'b0);
    repeat (BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    chk("break_no_false_start", {31'd0, rx_active}, 32'd0);
    repeat (2 * BIT_CLKS - BIT_CLKS / 2) @(negedge clk);
    rx_bit = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("ferr_count", ferr_seen, 1);
    chk("word_after_ferr", {24'd0, rx_word}, 32'h80);
    push_done(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("after_break_done_count", done_seen, 6);

    // Reset during data bit 4 discards the partial frame.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(8'hC3 >> i);
    rx_bit = 1'b0;
    repeat (40) @(negedge clk);
    chk("pre_reset_active", {31'd0, rx_active}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_rx_word", {24'd0, rx_word}, 32'h00);
    chk("midreset_rx_active", {31'd0, rx_active}, 32'd0);
    chk("midreset_rx_done", {31'd0, rx_done}, 32'd0);
    chk("midreset_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
    model_word = 8'h00;
    rx_bit = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    push_done(8'hC3);
    send_frame(8'hC3, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("post_reset_done_count", done_seen, 7);

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 2000 && expq.size() != 0; i++) @(negedge clk);
    chk("queue_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
